// File: rtl/sequence_generator.sv
// Serial pattern transmitter: captures a parallel pattern on start and sends it MSB-first,
// optionally repeating it with fixed idle gaps between passes.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_SHIFT | presenting pattern bits, one per cycle
//   S_GAP   | idle gap between passes, still busy
//   S_DONE  | one-cycle completion pulse
module sequence_generator #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t             r_state, w_state_n;
  logic [WIDTH-1:0]   r_pat, w_pat_n;
  logic [LEN_W-1:0]   r_len, w_len_n;
  logic [LEN_W-1:0]   r_bit, w_bit_n;
  logic [REP_W-1:0]   r_pass, w_pass_n;
  logic [GAP_W-1:0]   r_gap, w_gap_n;
  logic               r_x, w_x_n;
  logic               r_x_valid, w_x_valid_n;
  logic               r_busy, w_busy_n;
  logic               r_done, w_done_n;
  logic [LEN_W-1:0]   w_len_eff;
  logic [REP_W-1:0]   w_reps_eff;

  function automatic logic sel_bit(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
    return |(p & (WIDTH'(1) << i));
  endfunction

  assign w_len_eff  = (len == '0 || len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
  assign w_reps_eff = (reps == '0) ? REP_W'(1) : reps;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pat     <= '0;
      r_len     <= '0;
      r_bit     <= '0;
      r_pass    <= '0;
      r_gap     <= '0;
      r_x       <= 1'b0;
      r_x_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_pat     <= w_pat_n;
      r_len     <= w_len_n;
      r_bit     <= w_bit_n;
      r_pass    <= w_pass_n;
      r_gap     <= w_gap_n;
      r_x       <= w_x_n;
      r_x_valid <= w_x_valid_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
    end
  end

  // Outputs are computed for the cycle after the edge, so x always matches the registered index.
  always_comb begin
    w_state_n   = r_state;
    w_pat_n     = r_pat;
    w_len_n     = r_len;
    w_bit_n     = r_bit;
    w_pass_n    = r_pass;
    w_gap_n     = r_gap;
    w_x_n       = 1'b0;
    w_x_valid_n = 1'b0;
    w_busy_n    = 1'b0;
    w_done_n    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_n   = S_SHIFT;
          w_pat_n     = pattern;
          w_len_n     = w_len_eff;
          w_bit_n     = w_len_eff - LEN_W'(1);
          w_pass_n    = w_reps_eff - REP_W'(1);
          w_x_n       = sel_bit(pattern, w_len_eff - LEN_W'(1));
          w_x_valid_n = 1'b1;
          w_busy_n    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_state_n = S_IDLE;
        end else if (r_bit != '0) begin
          w_bit_n     = r_bit - LEN_W'(1);
          w_x_n       = sel_bit(r_pat, r_bit - LEN_W'(1));
          w_x_valid_n = 1'b1;
          w_busy_n    = 1'b1;
        end else if (r_pass != '0) begin
          w_pass_n = r_pass - REP_W'(1);
          w_busy_n = 1'b1;
          if (GAP > 0) begin
            w_state_n = S_GAP;
            w_gap_n   = GAP_W'(GAP - 1);
          end else begin
            w_bit_n     = r_len - LEN_W'(1);
            w_x_n       = sel_bit(r_pat, r_len - LEN_W'(1));
            w_x_valid_n = 1'b1;
          end
        end else begin
          w_state_n = S_DONE;
          w_done_n  = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          w_state_n = S_IDLE;
        end else if (r_gap != '0) begin
          w_gap_n  = r_gap - GAP_W'(1);
          w_busy_n = 1'b1;
        end else begin
          w_state_n   = S_SHIFT;
          w_bit_n     = r_len - LEN_W'(1);
          w_x_n       = sel_bit(r_pat, r_len - LEN_W'(1));
          w_x_valid_n = 1'b1;
          w_busy_n    = 1'b1;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign x       = r_x;
  assign x_valid = r_x_valid;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: a per-cycle expected-output queue built from the pattern rules,
// plus directed scenarios with hand-computed bit sequences and counts.
module tb_sequence_generator;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
  localparam int REP_W = 4;
  localparam int GAP   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic [REP_W-1:0] reps = '0;
  logic             x, x_valid, busy, done;

  int checks = 0;
  int errors = 0;

  sequence_generator #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .abort(abort), .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: each queue entry is {x, x_valid, busy, done} for one upcoming cycle.
  logic [3:0] cur = 4'b0;
  logic [3:0] q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      cur = 4'b0;
    end else if (q.size() > 0 || cur[0]) begin
      if (abort) begin
        q.delete();
        cur = 4'b0;
      end else if (q.size() > 0) cur = q.pop_front();
      else cur = 4'b0;
    end else if (start && !abort) begin
      int l, r;
      logic [WIDTH-1:0] t;
      l = (len == 0 || len > WIDTH) ? WIDTH : int'(len);
      r = (reps == 0) ? 1 : int'(reps);
      for (int p = 0; p < r; p++) begin
        for (int b = l - 1; b >= 0; b--) begin
          t = pattern >> b;
          q.push_back({t[0], 1'b1, 1'b1, 1'b0});
        end
        if (p < r - 1) for (int g = 0; g < GAP; g++) q.push_back(4'b0010);
      end
      q.push_back(4'b0001);
      cur = q.pop_front();
    end else begin
      cur = 4'b0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ({x, x_valid, busy, done} !== cur) begin
        errors++;
        $display("FAIL cycle_compare t=%0t x/xv/busy/done got %b required %b",
                 $time, {x, x_valid, busy, done}, cur);
      end
    end
  end

  // Observation counters and a simple three-ones detector fed by x.
  logic [31:0] seen = '0;
  int n_seen = 0, busy_cnt = 0, done_cnt = 0, y_cnt = 0;
  int run = 0;
  logic y;
  assign y = (run >= 3);

  always @(posedge clk or negedge reset) begin
    if (!reset) run <= 0;
    else run <= (x_valid && x) ? run + 1 : 0;
  end

  always @(negedge clk) begin
    if (x_valid) begin
      seen = {seen[30:0], x};
      n_seen++;
    end
    busy_cnt += int'(busy);
    done_cnt += int'(done);
    y_cnt    += int'(y);
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l, input logic [REP_W-1:0] r);
    @(negedge clk);
    seen = '0; n_seen = 0; busy_cnt = 0; done_cnt = 0; y_cnt = 0;
    pattern = p; len = l; reps = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pattern = ~p; len = 4'd5; reps = 4'd7;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for done got 0 required 1", name);
    end
    @(negedge clk);
  endtask

  initial begin
    #1 chk("reset_outputs", int'({x, x_valid, busy, done}), 0);
    #6 reset = 1'b1;

    send(8'b0000_0111, 4'd3, 4'd1);
    wait_done("single");
    chk("single_bits", int'(seen), 7);
    chk("single_nbits", n_seen, 3);
    chk("single_busy", busy_cnt, 3);
    chk("single_done", done_cnt, 1);

    send(8'b1010_0000, 4'd8, 4'd2);
    wait_done("repeat");
    chk("repeat_bits", int'(seen), 32'hA0A0);
    chk("repeat_nbits", n_seen, 16);
    chk("repeat_busy", busy_cnt, 18);
    chk("repeat_done", done_cnt, 1);

    send(8'hA5, 4'd0, 4'd0);
    wait_done("clamp");
    chk("clamp_bits", int'(seen), 32'hA5);
    chk("clamp_nbits", n_seen, 8);
    chk("clamp_busy", busy_cnt, 8);

    send(8'b1101_0110, 4'd8, 4'd1);
    start = 1'b1; pattern = 8'h00; len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_xvalid", int'(x_valid), 0);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_bits", int'(seen), 6);
    chk("abort_nbits", n_seen, 3);
    chk("abort_no_done", done_cnt, 0);

    start = 1'b1; abort = 1'b1; pattern = 8'hFF; len = 4'd8; reps = 4'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    chk("abort_start_idle_later", int'(busy), 0);

    send(8'h03, 4'd4, 4'd3);
    repeat (7) @(negedge clk);
    chk("second_pass_busy", int'(busy), 1);
    chk("second_pass_valid", int'(x_valid), 1);
    #1 reset = 1'b0;
    #1 chk("async_reset", int'({x, x_valid, busy, done}), 0);
    #1 reset = 1'b1;
    send(8'b0000_0111, 4'd3, 4'd1);
    wait_done("after_reset");
    chk("after_reset_bits", int'(seen), 7);
    chk("after_reset_nbits", n_seen, 3);
    chk("after_reset_done", done_cnt, 1);

    send(8'b0000_1111, 4'd4, 4'd1);
    wait_done("loopback");
    repeat (2) @(negedge clk);
    chk("loopback_bits", int'(seen), 15);
    chk("loopback_y_cycles", y_cnt, 2);
    chk("loopback_y_low", int'(y), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
